vga_frame_monitor: RTL and testbench
====================================

# vga_frame_monitor

Synthesizable, parametrised VGA stream monitor that sits on the `vs`/`hs`/`r`/`g`/`b` outputs of `top_warships`. It measures line period and frame height from the sync edges and flags deviations from the configured timing. It also folds every pixel of each frame into a 32-bit MISR signature. Benches and on-chip debug logic can then self-check whole frames at any colour depth or resolution without dumping image files.

## Interface
- `COLOR_BITS`, 4: bits per colour channel; `3*COLOR_BITS` ≤ 32
- `H_TOTAL`, 1344: expected clocks between consecutive hs leading edges
- `V_TOTAL`, 806: expected hs leading edges per frame
- `SYNC_ACTIVE_LOW`, 1: 1 = leading edge is the 1→0 transition, 0 = the 0→1 transition (applies to hs and vs)
- `CNT_W`, 16: width of the measurement counters
- `POLY`, 32'h04C1_1DB7: MISR feedback polynomial
- `SEED`, 32'hFFFF_FFFF: MISR start value
- `clk`  in  1  pixel clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `clr`  in  1  synchronous clear of sticky errors and `frame_cnt`
- `vs`, `hs`  in  1 each  sync inputs, synchronous to `clk`
- `r`, `g`, `b`  in  COLOR_BITS each  pixel colour
- `locked`  out  1  first vs leading edge seen
- `frame_done`  out  1  one-cycle pulse per completed frame
- `frame_sig`  out  32  signature of the last completed frame
- `line_len`  out  CNT_W  last measured hs period, in clocks
- `frame_lines`  out  CNT_W  last measured lines per frame
- `frame_cnt`  out  CNT_W  completed frames, saturating
- `err_h`, `err_v`  out  1 each  sticky timing-mismatch flags

## Operation
- Edge detection: `vs_q`/`hs_q` register the previous sample. A leading edge is detected in the cycle where the previous sample is inactive and the current input is active. No extra synchronizer is used.
- FSM states:
  - UNLOCKED: entered on reset; all counting and the MISR are frozen.
  - LOCKED: entered on the first vs leading edge. The accumulator loads SEED and counters clear. No frame is reported for the edge that causes the lock.
- hcnt: loads 0 in any hs-leading-edge cycle, otherwise increments and saturates at all-ones.
- Measured period: `hcnt+1`.
- At every hs leading edge except the first after lock:
  - `line_len` ← period.
  - If period ≠ H_TOTAL, set `err_h`.
- vcnt counts hs leading edges in the frame interval: after the previous vs edge cycle, up to and including the current vs edge cycle. It saturates.
- At a vs leading edge in LOCKED, with lines = vcnt plus 1 if an hs leading edge also occurs this cycle:
  - `frame_lines` ← lines.
  - If lines ≠ V_TOTAL, set `err_v`.
  - `frame_sig` ← the MISR value that includes this cycle's pixel.
  - Accumulator ← SEED and vcnt ← 0.
  - `frame_cnt` increments, saturating.
  - `frame_done` pulses.
- MISR step, applied every LOCKED cycle:
  - `acc ← {acc[30:0],1'b0} ^ (acc[31] ? POLY : 0) ^ zext32({r,g,b})`.
  - `r` occupies the MSBs of the pixel word.
  - Blanking pixels are included.
- `clr`:
  - Zeroes `err_h`, `err_v` and `frame_cnt`.
  - If an error or a frame completes in the same cycle, the set or increment wins: the error flag ends up 1 and `frame_cnt` ends up 1.
  - Does not affect the lock state or the MISR.

## Timing
- All outputs are registered. Outputs update at the clock edge following the detection cycle, i.e. one cycle after the input shows its active level.
- Reset values:
  - `locked`, `frame_done`, `err_h`, `err_v` = 0.
  - `frame_sig` = 0.
  - `line_len`, `frame_lines`, `frame_cnt` = 0.
  - Internal accumulator = SEED; hcnt and vcnt = 0.
- `rst` asserted mid-frame returns the block to UNLOCKED next cycle. The partial frame is discarded and no `frame_done` is issued.
- Sync inputs held active produce no further edges.
- Counters saturate at `2^CNT_W−1`, so they never wrap.
- `frame_done` is high for exactly 1 cycle per frame, and never in the cycle after lock.

## Test plan
- **Nominal frames.** Use `H_TOTAL`=10, `V_TOTAL`=6 and a stimulus with exactly those totals, all pixels 0, running 3 frames.
  - `locked` rises 1 cycle after the first vs edge.
  - `frame_done` pulses 60 clocks apart.
  - `line_len`=10, `frame_lines`=6, `frame_cnt`=3, `err_h`=`err_v`=0.
  - `frame_sig` equals the bench MISR model applied to 60 zero words from SEED.
- **Signature sensitivity.** Repeat the nominal run, flipping one bit of `g` in one pixel of frame 2.
  - Frame 2 signature differs from frames 1 and 3.
  - Frames 1 and 3 are identical.
- **Short line.** Insert one 9-clock hs period.
  - `line_len`=9 at that edge.
  - `err_h`=1 and stays 1 after timing is restored.
  - `err_v`=0.
- **Wrong height.** Use a 7-line frame.
  - `frame_lines`=7 and `err_v`=1.
  - A following correct frame shows `frame_lines`=6 with `err_v` still 1.
- **`clr` collision.** Pulse `clr` in the same cycle as a vs edge while `err_v` is set and the frame height is correct.
  - `err_v`=0 and `frame_cnt`=1.
  - Repeating with a wrong-height frame leaves `err_v`=1.
- **Reset mid-frame.** Assert `rst` at line 3 of frame 2.
  - All outputs return to 0 and `locked`=0.
  - No `frame_done` until one full frame after the next vs edge.

Source files
------------

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: measures VGA line/frame timing and folds every pixel of each frame into a MISR signature
module vga_frame_monitor #(
  parameter int          COLOR_BITS      = 4,
  parameter int          H_TOTAL         = 1344,
  parameter int          V_TOTAL         = 806,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int          CNT_W           = 16,
  parameter logic [31:0] POLY            = 32'h04C1_1DB7,
  parameter logic [31:0] SEED            = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  vs,
  input  logic                  hs,
  input  logic [COLOR_BITS-1:0] r,
  input  logic [COLOR_BITS-1:0] g,
  input  logic [COLOR_BITS-1:0] b,
  output logic                  locked,
  output logic                  frame_done,
  output logic [31:0]           frame_sig,
  output logic [CNT_W-1:0]      line_len,
  output logic [CNT_W-1:0]      frame_lines,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic                  err_h,
  output logic                  err_v
);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  localparam logic             IDLE  = SYNC_ACTIVE_LOW;
  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [CNT_W-1:0] H_EXP = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] V_EXP = CNT_W'(V_TOTAL);
  state_t           state_q, state_d;
  logic             vs_q, hs_q, vs_edge, hs_edge;
  logic             h_seen_q, h_seen_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, period, lines;
  logic [31:0]      acc_q, acc_d, acc_nxt, pix;
  logic             locked_q, locked_d, frame_done_q, frame_done_d;
  logic             err_h_q, err_h_d, err_v_q, err_v_d;
  logic [31:0]      frame_sig_q, frame_sig_d;
  logic [CNT_W-1:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d, frame_cnt_q, frame_cnt_d;
  assign vs_edge     = (vs != IDLE) && (vs_q == IDLE);
  assign hs_edge     = (hs != IDLE) && (hs_q == IDLE);
  assign locked      = locked_q;
  assign frame_done  = frame_done_q;
  assign frame_sig   = frame_sig_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_h       = err_h_q;
  assign err_v       = err_v_q;
  // Datapath helpers: next MISR value, measured line period and line count including this cycle's hs edge
  always_comb begin
    pix = '0;
    pix[3*COLOR_BITS-1:0] = {r, g, b};
    acc_nxt = {acc_q[30:0], 1'b0} ^ (acc_q[31] ? POLY : 32'd0) ^ pix;
    period  = (hcnt_q == CMAX) ? CMAX : hcnt_q + CNT_W'(1);
    lines   = hs_edge ? ((vcnt_q == CMAX) ? CMAX : vcnt_q + CNT_W'(1)) : vcnt_q;
  end
  // Lock FSM, counters, signature and sticky flags; a set or increment beats a same-cycle clr
  always_comb begin
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    h_seen_d      = h_seen_q;
    acc_d         = acc_q;
    frame_done_d  = 1'b0;
    frame_sig_d   = frame_sig_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    frame_cnt_d   = clr ? '0 : frame_cnt_q;
    err_h_d       = err_h_q & ~clr;
    err_v_d       = err_v_q & ~clr;
    if (state_q == UNLOCKED) begin
      if (vs_edge) begin
        state_d  = LOCKED;
        acc_d    = SEED;
        hcnt_d   = '0;
        vcnt_d   = '0;
        h_seen_d = 1'b0;
      end
    end else begin
      acc_d  = acc_nxt;
      hcnt_d = hs_edge ? '0 : ((hcnt_q == CMAX) ? CMAX : hcnt_q + CNT_W'(1));
      if (hs_edge) begin
        h_seen_d = 1'b1;
        vcnt_d   = lines;
        if (h_seen_q) begin
          line_len_d = period;
          err_h_d    = err_h_d | (period != H_EXP);
        end
      end
      if (vs_edge) begin
        vcnt_d        = '0;
        frame_lines_d = lines;
        err_v_d       = err_v_d | (lines != V_EXP);
        frame_sig_d   = acc_nxt;
        acc_d         = SEED;
        frame_cnt_d   = clr ? CNT_W'(1) : ((frame_cnt_q == CMAX) ? CMAX : frame_cnt_q + CNT_W'(1));
        frame_done_d  = 1'b1;
      end
    end
    locked_d = (state_d == LOCKED);
  end
  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= UNLOCKED;
      vs_q          <= IDLE;
      hs_q          <= IDLE;
      h_seen_q      <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      acc_q         <= SEED;
      locked_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_sig_q   <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      frame_cnt_q   <= '0;
      err_h_q       <= 1'b0;
      err_v_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs;
      hs_q          <= hs;
      h_seen_q      <= h_seen_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      acc_q         <= acc_d;
      locked_q      <= locked_d;
      frame_done_q  <= frame_done_d;
      frame_sig_q   <= frame_sig_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      frame_cnt_q   <= frame_cnt_d;
      err_h_q       <= err_h_d;
      err_v_q       <= err_v_d;
    end
  end
endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor: directed and randomized frames checked against an event-level timing/signature model
module tb_vga_frame_monitor;
  localparam int          H    = 10;
  localparam int          V    = 6;
  localparam int          CW   = 16;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [31:0] SEED = 32'hFFFF_FFFF;
  logic clk = 1'b0;
  logic rst, clr, vs, hs;
  logic [3:0] r, g, b;
  logic locked, frame_done, err_h, err_v;
  logic [31:0] frame_sig;
  logic [CW-1:0] line_len, frame_lines, frame_cnt;
  int n_chk = 0;
  int n_fail = 0;
  vga_frame_monitor #(
    .COLOR_BITS(4), .H_TOTAL(H), .V_TOTAL(V), .SYNC_ACTIVE_LOW(1'b1),
    .CNT_W(CW), .POLY(POLY), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .vs(vs), .hs(hs), .r(r), .g(g), .b(b),
    .locked(locked), .frame_done(frame_done), .frame_sig(frame_sig),
    .line_len(line_len), .frame_lines(frame_lines), .frame_cnt(frame_cnt),
    .err_h(err_h), .err_v(err_v)
  );
  always #5 clk = ~clk;
  int t = 0;
  int last_h = 0;
  int nl = 0;
  bit m_lock = 1'b0;
  bit h_seen = 1'b0;
  bit p_vs = 1'b1;
  bit p_hs = 1'b1;
  logic [31:0] mq[$];
  logic [31:0] zq[$];
  logic [31:0] zsig;
  logic [31:0] e_lock = 0, e_fd = 0, e_eh = 0, e_ev = 0, e_sig = 0, e_ll = 0, e_fl = 0, e_cnt = 0;
  function automatic logic [31:0] misr(input logic [31:0] w[$]);
    logic [31:0] a;
    a = SEED;
    foreach (w[i]) a = {a[30:0], 1'b0} ^ (a[31] ? POLY : 32'd0) ^ w[i];
    return a;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at t=%0d", tag, got, exp, t);
    end
  endtask
  task automatic tick(input logic v, input logic h, input logic [3:0] pr, input logic [3:0] pg,
                      input logic [3:0] pb, input logic c, input logic rs);
    bit ve, he;
    int p;
    vs = v; hs = h; r = pr; g = pg; b = pb; clr = c; rst = rs;
    @(posedge clk);
    #1;
    t++;
    if (rs) begin
      m_lock = 1'b0; p_vs = 1'b1; p_hs = 1'b1; mq.delete();
      e_lock = 0; e_fd = 0; e_eh = 0; e_ev = 0; e_sig = 0; e_ll = 0; e_fl = 0; e_cnt = 0;
    end else begin
      ve = !v && p_vs;
      he = !h && p_hs;
      e_fd = 0;
      if (c) begin
        e_eh = 0; e_ev = 0; e_cnt = 0;
      end
      if (!m_lock) begin
        if (ve) begin
          m_lock = 1'b1; e_lock = 1; last_h = t; h_seen = 1'b0; nl = 0; mq.delete();
        end
      end else begin
        mq.push_back({20'd0, pr, pg, pb});
        if (he) begin
          p = (t - last_h > 65535) ? 65535 : t - last_h;
          if (h_seen) begin
            e_ll = p;
            if (p != H) e_eh = 1;
          end
          h_seen = 1'b1;
          last_h = t;
          if (nl < 65535) nl++;
        end
        if (ve) begin
          e_fl = nl;
          if (nl != V) e_ev = 1;
          e_sig = misr(mq);
          mq.delete();
          nl = 0;
          if (e_cnt < 65535) e_cnt++;
          e_fd = 1;
        end
      end
      p_vs = v;
      p_hs = h;
    end
    check("locked", 32'(locked), e_lock);
    check("frame_done", 32'(frame_done), e_fd);
    check("frame_sig", frame_sig, e_sig);
    check("line_len", 32'(line_len), e_ll);
    check("frame_lines", 32'(frame_lines), e_fl);
    check("frame_cnt", 32'(frame_cnt), e_cnt);
    check("err_h", 32'(err_h), e_eh);
    check("err_v", 32'(err_v), e_ev);
  endtask
  task automatic run_frame(input int nlines, input int sl, input int slen, input bit rp,
                           input int flip, input bit cf, input int rl, input bit rc);
    int k;
    int len;
    logic [3:0] pr, pg, pb;
    k = 0;
    for (int ln = 0; ln < nlines; ln++) begin
      len = (ln == sl) ? slen : H;
      for (int c = 0; c < len; c++) begin
        pr = rp ? 4'($urandom) : 4'd0;
        pg = rp ? 4'($urandom) : 4'd0;
        pb = rp ? 4'($urandom) : 4'd0;
        if (k == flip) pg = pg ^ 4'd1;
        tick(!(ln == 0 && c < 3), !(c < 2), pr, pg, pb,
             (cf && k == 0) || (rc && $urandom_range(49) == 0), ln == rl && c == 5);
        k++;
      end
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int nl2, sl2, sln, rl2;
    repeat (60) zq.push_back(32'd0);
    zsig = misr(zq);
    repeat (3) tick(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    repeat (4) tick(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    repeat (4) run_frame(V, -1, 0, 1'b0, -1, 1'b0, -1, 1'b0);
    check("nom_cnt", 32'(frame_cnt), 3);
    check("nom_line_len", 32'(line_len), 10);
    check("nom_lines", 32'(frame_lines), 6);
    check("nom_err", {30'd0, err_h, err_v}, 0);
    check("nom_sig", frame_sig, zsig);
    run_frame(V, -1, 0, 1'b0, 25, 1'b0, -1, 1'b0);
    run_frame(V, -1, 0, 1'b0, -1, 1'b0, -1, 1'b0);
    check("sens_f2_differs", 32'(frame_sig != zsig), 1);
    run_frame(V, -1, 0, 1'b0, -1, 1'b0, -1, 1'b0);
    check("sens_f3_same", frame_sig, zsig);
    run_frame(V, 2, 9, 1'b1, -1, 1'b0, -1, 1'b0);
    run_frame(V, -1, 0, 1'b1, -1, 1'b0, -1, 1'b0);
    check("short_err_h", 32'(err_h), 1);
    check("short_err_v", 32'(err_v), 0);
    run_frame(7, -1, 0, 1'b1, -1, 1'b0, -1, 1'b0);
    run_frame(V, -1, 0, 1'b1, -1, 1'b0, -1, 1'b0);
    check("tall_lines", 32'(frame_lines), 7);
    check("tall_err_v", 32'(err_v), 1);
    run_frame(V, -1, 0, 1'b1, -1, 1'b0, -1, 1'b0);
    check("tall_next_lines", 32'(frame_lines), 6);
    check("tall_next_err_v", 32'(err_v), 1);
    run_frame(V, -1, 0, 1'b1, -1, 1'b1, -1, 1'b0);
    check("clr_ok_err_v", 32'(err_v), 0);
    check("clr_ok_cnt", 32'(frame_cnt), 1);
    run_frame(7, -1, 0, 1'b1, -1, 1'b0, -1, 1'b0);
    run_frame(V, -1, 0, 1'b1, -1, 1'b1, -1, 1'b0);
    check("clr_bad_err_v", 32'(err_v), 1);
    check("clr_bad_cnt", 32'(frame_cnt), 1);
    run_frame(V, -1, 0, 1'b1, -1, 1'b0, -1, 1'b0);
    run_frame(V, -1, 0, 1'b1, -1, 1'b0, 3, 1'b0);
    check("rst_locked", 32'(locked), 0);
    check("rst_outs", {frame_sig ^ 32'(line_len) ^ 32'(frame_lines) ^ 32'(frame_cnt)}, 0);
    check("rst_flags", {29'd0, frame_done, err_h, err_v}, 0);
    run_frame(V, -1, 0, 1'b1, -1, 1'b0, -1, 1'b0);
    run_frame(V, -1, 0, 1'b1, -1, 1'b0, -1, 1'b0);
    check("relock_cnt", 32'(frame_cnt), 1);
    for (int f = 0; f < 25; f++) begin
      nl2 = ($urandom_range(3) == 0) ? 5 + 2 * int'($urandom_range(1)) : V;
      sl2 = ($urandom_range(3) == 0) ? int'($urandom_range(nl2 - 1)) : -1;
      sln = 9 + int'($urandom_range(2));
      rl2 = ($urandom_range(9) == 0) ? 2 : -1;
      run_frame(nl2, sl2, sln, 1'b1, -1, 1'b0, rl2, 1'b1);
    end
    run_frame(V, -1, 0, 1'b1, -1, 1'b0, -1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
